cpu_ctrl: RTL and testbench
===========================

// Module: cpu_ctrl
// PURPOSE
//  Multi-cycle fetch/decode/execute controller; the issuing side of the ALU interface.
//  - Fetches 8-bit instructions over a req/ack port.
//  - Reads its 4x8 register file and drives alu_a/alu_b/alu_op.
//  - Captures the ALU's registered result (1-cycle latency) and writes it back.
//  - Also handles load-immediate, output port, halt and optional branch-if-zero.
// PARAMETERS
//  RESET_PC  8'h00  PC value after reset
//  IMEM_AW   8      instruction address width; PC wraps modulo 2**IMEM_AW
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  imem_addr   out  IMEM_AW  fetch address, equals PC (or PC+1 for the operand byte)
//  imem_req    out  1        fetch request
//  imem_ack    in   1        fetch complete; imem_data valid this cycle
//  imem_data   in   8        instruction/operand byte
//  alu_a       out  8        ALU operand A = R[rd]
//  alu_b       out  8        ALU operand B = R[rs]
//  alu_op      out  3        ALU function select
//  alu_result  in   8        ALU registered result
//  out_data    out  8        output port data
//  out_valid   out  1        output port valid
//  out_ready   in   1        output port ready
//  halted      out  1        high in HALT state
//  zflag       out  1        zero flag of last ALU writeback
// BEHAVIOUR
//  Reset (async, any state):
//    state=IDLE, PC=RESET_PC, R0..R3=0, zflag=0, alu_a/alu_b/alu_op=0, out_data=0.
//    imem_req, out_valid and halted are combinational from state, so all three are 0 in reset.
//  Reset mid-transaction abandons it; a late imem_ack in IDLE is ignored.
//  Encoding:
//    [7:5] != 3'b111: ALU instruction; rd=[4:3], rs=[2:1], bit0 ignored; alu_op=[7:5].
//      Codes: 000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 CLR(0), 101 OR, 110 AND.
//    [7:5] == 3'b111: system instruction; rd=[4:3], sub=[2:0]:
//      000 LDI  (next byte -> R[rd])
//      001 OUT  (R[rd] -> out port)
//      010 HALT
//      011 BRZ  (next byte = target)
//      others NOP
//  States and transitions:
//    IDLE  -> FETCH (unconditional, 1 cycle).
//    FETCH: imem_req=1, addr=PC, held stable until ack.
//           On ack: latch IR, PC<=PC+1 (wraps 0xFF->0x00), -> DECODE.
//    DECODE: register alu_a=R[rd], alu_b=R[rs], alu_op=IR[7:5].
//           ALU instruction -> EXEC. LDI/BRZ -> OPND. OUT -> OUT. HALT -> HALT. NOP -> FETCH.
//    EXEC: ALU inputs stable; the ALU registers its result at the end of this cycle. -> WB.
//    WB:   R[rd]<=alu_result; zflag<=(alu_result==0). -> FETCH.
//          alu_a/alu_b/alu_op held from DECODE through WB.
//          ALU instruction = fetch + 3 cycles.
//    OPND: imem_req=1, addr=PC. On ack: PC<=PC+1.
//          LDI: R[rd]<=imem_data; zflag unchanged.
//          BRZ: if zflag, PC<=imem_data. -> FETCH.
//    OUT:  out_valid=1, out_data=R[rd] (registered in DECODE, stable while valid).
//          Transfer on valid&&ready -> FETCH. Stalls indefinitely without ready.
//    HALT: terminal; only reset exits. halted=1, no requests.
//  Arithmetic:
//    8-bit registers; PC+1 mod 2**IMEM_AW; no carry captured.
//    rd==rs is legal (A and B are the same register).
//  Writeback and the next DECODE never overlap (strictly sequential), so no forwarding is needed.
//  imem_ack outside FETCH/OPND is ignored.
// CONFIGURATION
//  CPU_CTRL_BRZ_EN defined:   sub 011 is BRZ as above.
//  CPU_CTRL_BRZ_EN undefined: sub 011 decodes as NOP (no operand fetch, PC+1 only);
//                             zflag is still maintained.
// STRUCTURE
//  cpu_defs package/include:
//    - state encodings (IDLE, FETCH, DECODE, EXEC, WB, OPND, OUT, HALT)
//    - ALU op codes and system sub-op codes
//    - field bit positions
//  Sub-module cpu_regfile: 4x8, two async read ports, one sync write port, async reset to 0.
// TESTING (bench: behavioural ALU with 1-cycle registered result)
//  1. Reset: rst_n=0 -> imem_req=0, halted=0, out_valid=0.
//     Release -> after IDLE, req with addr=00.
//  2. Program LDI R1,0x05; LDI R2,0x03; ADD R1,R2; OUT R1
//     -> alu_op=000, a=05, b=03 during EXEC; out_data=0x08 on handshake.
//  3. SUB R1,R1 -> R1=0, zflag=1.
//     BRZ 0x40 -> next imem_addr=0x40.
//     Without CPU_CTRL_BRZ_EN -> next addr = PC+1.
//  4. imem_ack delayed 5 cycles -> imem_addr stable, no state advance.
//     OUT with out_ready low 10 cycles -> out_valid and out_data held.
//  5. Straight-line code with PC at 0xFF -> next fetch at 0x00.
//     HALT -> halted=1, no further imem_req.
//  6. Assert rst_n during EXEC and during OPND -> immediate IDLE, regs cleared, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state encodings, opcode/sub-op codes and instruction field positions for cpu_ctrl.
package cpu_ctrl_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_OPND   = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_CLR, OP_OR, OP_AND, OP_SYS
    } alu_op_e;

    typedef enum logic [2:0] {
        SUB_LDI, SUB_OUT, SUB_HALT, SUB_BRZ
    } sys_sub_e;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 1;
    localparam int SUB_MSB = 2;
    localparam int SUB_LSB = 0;
endpackage

// File: rtl/cpu_ctrl_regfile.sv
// cpu_regfile: 4x8 register file, two async read ports, one sync write port, async clear.
module cpu_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ra_addr,
    input  logic [1:0] rb_addr,
    output logic [7:0] ra_data,
    output logic [7:0] rb_data,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [7:0] wd
);
    logic [3:0][7:0] regs;

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            regs <= '0;
        else if (we)
            regs[wa] <= wd;
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute controller issuing to an external 1-cycle ALU.
// Define CPU_CTRL_BRZ_EN to decode sub-op 011 as branch-if-zero; otherwise it is a NOP.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int                  IMEM_AW  = 8,
    parameter logic [IMEM_AW-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [7:0]         imem_data,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [2:0]         alu_op,
    input  logic [7:0]         alu_result,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halted,
    output logic               zflag
);
    logic [2:0]         state;
    logic [2:0]         dec_next;
    logic [IMEM_AW-1:0] pc;
    logic [7:0]         ir;
    logic [7:0]         ra_data;
    logic [7:0]         rb_data;
    logic [7:0]         rf_wd;
    logic [2:0]         sub;
    logic               sys;
    logic               is_ldi;
    logic               is_out;
    logic               is_brz;
    logic               rf_we;

    assign sub    = ir[SUB_MSB:SUB_LSB];
    assign sys    = ir[OP_MSB:OP_LSB] == OP_SYS;
    assign is_ldi = sys && sub == SUB_LDI;
    assign is_out = sys && sub == SUB_OUT;
`ifdef CPU_CTRL_BRZ_EN
    assign is_brz = sys && sub == SUB_BRZ;
`else
    assign is_brz = 1'b0;
`endif

    assign imem_req  = state == S_FETCH || state == S_OPND;
    assign imem_addr = pc;
    assign out_valid = state == S_OUT;
    assign halted    = state == S_HALT;

    always_comb begin
        dec_next = !sys                ? S_EXEC :
                   is_ldi || is_brz    ? S_OPND :
                   is_out              ? S_OUT  :
                   sub == SUB_HALT     ? S_HALT : S_FETCH;
        rf_we    = state == S_WB || (state == S_OPND && imem_ack && is_ldi);
        rf_wd    = state == S_WB ? alu_result : imem_data;
    end

    cpu_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ir[RD_MSB:RD_LSB]),
        .rb_addr (ir[RS_MSB:RS_LSB]),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (rf_we),
        .wa      (ir[RD_MSB:RD_LSB]),
        .wd      (rf_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            out_data <= '0;
            zflag    <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (imem_ack) begin
                              ir    <= imem_data;
                              pc    <= pc + IMEM_AW'(1);
                              state <= S_DECODE;
                          end
                S_DECODE: begin
                              alu_a  <= ra_data;
                              alu_b  <= rb_data;
                              alu_op <= ir[OP_MSB:OP_LSB];
                              if (is_out)
                                  out_data <= ra_data;
                              state  <= dec_next;
                          end
                S_EXEC:   state <= S_WB;
                S_WB:     begin
                              zflag <= alu_result == 8'd0;
                              state <= S_FETCH;
                          end
                // operand byte: LDI data is written through the regfile port, BRZ target loads PC
                S_OPND:   if (imem_ack) begin
                              pc    <= (is_brz && zflag) ? IMEM_AW'(imem_data) : pc + IMEM_AW'(1);
                              state <= S_FETCH;
                          end
                S_OUT:    if (out_ready) state <= S_FETCH;
                default:  state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed table-driven bench for cpu_ctrl with a behavioural 1-cycle ALU and memory.
module tb_cpu_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = '0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       halted;
    logic       zflag;

    always #5 clk = ~clk;

    cpu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted),
        .zflag      (zflag)
    );

    logic [7:0] mem [256];
    int         lat = 0;
    int         wcnt = 0;

    always @(posedge clk) begin
        imem_ack <= 1'b0;
        if (imem_req && !imem_ack) begin
            if (wcnt >= lat) begin
                imem_ack  <= 1'b1;
                imem_data <= mem[imem_addr];
                wcnt      <= 0;
            end else
                wcnt <= wcnt + 1;
        end else
            wcnt <= 0;
    end

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << 1;
            3'd3:    return a >> 1;
            3'd5:    return a | b;
            3'd6:    return a & b;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_f(alu_op, alu_a, alu_b);

    logic [7:0] out_log = '0;
    int         out_cnt = 0;
    logic [7:0] addr_log [300];
    int         n_acc = 0;
    logic [2:0] lop = '0;
    logic [7:0] la = '0;
    logic [7:0] lb = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= 0;
            n_acc   <= 0;
        end else begin
            if (out_valid && out_ready) begin
                out_log <= out_data;
                out_cnt <= out_cnt + 1;
            end
            if (imem_req && imem_ack) begin
                if (n_acc < 300) addr_log[n_acc] <= imem_addr;
                n_acc <= n_acc + 1;
            end
            if (alu_op != 3'd7) begin
                lop <= alu_op;
                la  <= alu_a;
                lb  <= alu_b;
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_halt(input string nm);
        int c = 0;
        while (!halted && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_halt"}, halted, 1);
    endtask

    task automatic first_fetch(input string nm);
        int c = 0;
        while (!imem_req && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_req"}, imem_req, 1);
        chk({nm, "_addr"}, imem_addr, 0);
    endtask

    task automatic wait_ack(input logic [7:0] a, input string nm);
        int c = 0;
        while (!(imem_req && imem_ack && imem_addr == a) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(nm, imem_req && imem_ack && imem_addr == a, 1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] res;
        logic       z;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{3'd0, 2'd1, 2'd2, 8'h05, 8'h03, 8'h05, 8'h03, 8'h08, 1'b0};
        vecs[1]  = '{3'd1, 2'd1, 2'd2, 8'h05, 8'h05, 8'h05, 8'h05, 8'h00, 1'b1};
        vecs[2]  = '{3'd1, 2'd1, 2'd2, 8'h03, 8'h05, 8'h03, 8'h05, 8'hFE, 1'b0};
        vecs[3]  = '{3'd2, 2'd1, 2'd2, 8'h81, 8'h00, 8'h81, 8'h00, 8'h02, 1'b0};
        vecs[4]  = '{3'd3, 2'd1, 2'd2, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{3'd4, 2'd1, 2'd2, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h00, 1'b1};
        vecs[6]  = '{3'd5, 2'd1, 2'd2, 8'h50, 8'h05, 8'h50, 8'h05, 8'h55, 1'b0};
        vecs[7]  = '{3'd6, 2'd1, 2'd2, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'h00, 1'b1};
        vecs[8]  = '{3'd0, 2'd3, 2'd3, 8'h21, 8'h21, 8'h21, 8'h21, 8'h42, 1'b0};
        vecs[9]  = '{3'd0, 2'd0, 2'd2, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[10] = '{3'd3, 2'd2, 2'd1, 8'h80, 8'h33, 8'h80, 8'h33, 8'h40, 1'b0};

        // reset values, then IDLE for one cycle before the first fetch at 00
        fill(8'hE2);
        repeat (3) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_zflag", zflag, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        #1 chk("idle_no_req", imem_req, 0);
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        wait_halt("halt_prog");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("halt_no_req", imem_req, 0);
            chk("halt_stays", halted, 1);
        end

        // LDI rd,a; LDI rs,b; ALU rd,rs; OUT rd; HALT
        for (int i = 0; i < 11; i++) begin
            hold_reset();
            fill(8'hE2);
            mem[0] = {3'b111, vecs[i].rd, 3'b000};
            mem[1] = vecs[i].a;
            mem[2] = {3'b111, vecs[i].rs, 3'b000};
            mem[3] = vecs[i].b;
            mem[4] = {vecs[i].op, vecs[i].rd, vecs[i].rs, 1'b1};
            mem[5] = {3'b111, vecs[i].rd, 3'b001};
            mem[6] = 8'hE2;
            rst_n = 1'b1;
            wait_halt($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_out", i), out_log, vecs[i].res);
            chk($sformatf("vec%0d_outcnt", i), out_cnt, 1);
            chk($sformatf("vec%0d_z", i), zflag, vecs[i].z);
            chk($sformatf("vec%0d_op", i), lop, vecs[i].op);
            chk($sformatf("vec%0d_a", i), la, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), lb, vecs[i].eb);
        end

        // BRZ with zflag set by SUB R1,R1
        hold_reset();
        fill(8'hE2);
        mem[0] = 8'hE8; mem[1] = 8'h05; mem[2] = 8'h2A; mem[3] = 8'hE3; mem[4] = 8'h40;
        rst_n = 1'b1;
        wait_halt("brz_t");
        chk("brz_t_z", zflag, 1);
`ifdef CPU_CTRL_BRZ_EN
        chk("brz_t_target", addr_log[5], 8'h40);
`else
        chk("brz_t_target", addr_log[5], 8'h05);
`endif

        // BRZ with zflag clear falls through past its operand
        hold_reset();
        fill(8'hE2);
        mem[0] = 8'hE3; mem[1] = 8'h40;
        rst_n = 1'b1;
        wait_halt("brz_nt");
        chk("brz_nt_next", addr_log[2], 8'h02);

        // slow memory and stalled output port
        hold_reset();
        fill(8'hE2);
        lat = 5;
        out_ready = 1'b0;
        mem[0] = 8'hE8; mem[1] = 8'h77; mem[2] = 8'hE9;
        rst_n = 1'b1;
        first_fetch("slow");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("slow_req_held", imem_req, 1);
            chk("slow_addr_held", imem_addr, 0);
        end
        begin
            int c = 0;
            while (!out_valid && c < 100) begin
                @(negedge clk);
                c++;
            end
        end
        chk("stall_valid", out_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid_held", out_valid, 1);
            chk("stall_data_held", out_data, 8'h77);
        end
        out_ready = 1'b1;
        wait_halt("stall");
        chk("stall_out", out_log, 8'h77);
        chk("stall_outcnt", out_cnt, 1);
        lat = 0;

        // straight-line NOPs wrap the PC from FF to 00
        hold_reset();
        fill(8'hE4);
        rst_n = 1'b1;
        begin
            int c = 0;
            while (n_acc < 257 && c < 3000) begin
                @(negedge clk);
                c++;
            end
        end
        chk("wrap_run", n_acc >= 257, 1);
        chk("wrap_ff", addr_log[255], 8'hFF);
        chk("wrap_00", addr_log[256], 8'h00);

        // reset asserted during EXEC
        hold_reset();
        fill(8'hE2);
        mem[0] = 8'h20; mem[1] = 8'hE8; mem[2] = 8'h05; mem[3] = 8'hF0; mem[4] = 8'h03; mem[5] = 8'h0C;
        rst_n = 1'b1;
        wait_ack(8'h05, "exec_reach");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("exec_a", alu_a, 8'h05);
        chk("exec_b", alu_b, 8'h03);
        chk("exec_op", alu_op, 0);
        chk("exec_z", zflag, 1);
        rst_n = 1'b0;
        #1;
        chk("exec_rst_req", imem_req, 0);
        chk("exec_rst_a", alu_a, 0);
        chk("exec_rst_z", zflag, 0);
        fill(8'hE2);
        mem[0] = 8'hAC; mem[1] = 8'hE9;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first_fetch("exec_rel");
        wait_halt("exec_rel");
        chk("exec_regs_clr", out_log, 8'h00);
        chk("exec_rel_z", zflag, 1);

        // reset asserted during OPND of an LDI
        hold_reset();
        fill(8'hE2);
        mem[0] = 8'hE8; mem[1] = 8'h5A; mem[2] = 8'hE9;
        rst_n = 1'b1;
        wait_ack(8'h00, "opnd_reach");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("opnd_req", imem_req, 1);
        chk("opnd_addr", imem_addr, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("opnd_rst_req", imem_req, 0);
        fill(8'hE2);
        mem[0] = 8'hE9;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first_fetch("opnd_rel");
        wait_halt("opnd_rel");
        chk("opnd_r1_clr", out_log, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
